// File: rtl/gcd_pkg.sv
// gcd_pkg: state encoding, default operand width and id-width helper shared by gcd_arbiter.
package gcd_pkg;
  localparam int GCD_W = 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req at or after ptr, wrapping modulo N.
module rr_arbiter
  import gcd_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // Scan from the far end so the candidate nearest the pointer overwrites the rest.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[IW'((int'(ptr) + k) % N)]) idx = IW'((int'(ptr) + k) % N);
    gnt = N'(|req) << idx;
  end
endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end sharing one multi-cycle GCD core among N requesters.
// Define GCD_TIMEOUT_EN to add a RUN watchdog that aborts a run with err after TMO cycles.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int W   = GCD_W,
  parameter int N   = 4,
  parameter int TMO = 1024,
  localparam int IW = id_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  output logic [N-1:0]  ack,
  output logic [W-1:0]  res,
  output logic [IW-1:0] res_id,
  output logic          err,
  output logic          busy,
  output logic          core_start,
  output logic [W-1:0]  core_a,
  output logic [W-1:0]  core_b,
  input  logic          core_done,
  input  logic [W-1:0]  core_r
);
  if (N < 2 || N > 8 || TMO < 2) begin : g_bad_cfg
    $error("gcd_arbiter: N must be 2..8 and TMO at least 2");
  end
  state_t        state_q, state_d;
  logic [IW-1:0] id_q, id_d, ptr_q, ptr_d, win_idx;
  logic [N-1:0]  win_gnt;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic          tmo;
  rr_arbiter #(.N(N), .IW(IW)) u_rr (.req(req), .ptr(ptr_q), .gnt(win_gnt), .idx(win_idx));
`ifdef GCD_TIMEOUT_EN
  localparam int CW = $clog2(TMO);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign tmo = (cnt_q == CW'(TMO - 1));
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef GCD_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = (state_q == RUN) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: if (|req) begin
        state_d = LOAD;
        id_d    = win_idx;
        for (int i = 0; i < N; i++)
          if (win_gnt[i]) begin
            a_d = op_a[i*W +: W];
            b_d = op_b[i*W +: W];
          end
      end
      LOAD: state_d = RUN;
      RUN: if (core_done || tmo) begin
        state_d = RESP;
        res_d   = core_done ? core_r : '0;
`ifdef GCD_TIMEOUT_EN
        err_d   = !core_done;
`endif
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end
`ifdef GCD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif
  assign busy       = (state_q != IDLE);
  assign core_start = (state_q == RUN);
  assign ack        = (state_q == RESP) ? N'(1) << id_q : '0;
  assign res_id     = id_q;
  assign res        = res_q;
  assign core_a     = a_q;
  assign core_b     = b_q;
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: randomized scoreboard bench for gcd_arbiter driving a 5-cycle behavioural GCD core.
`timescale 1ns/1ps
module tb_gcd_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef GCD_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] op_a = '0;
  logic [N*W-1:0] op_b = '0;
  logic [N-1:0] ack;
  logic [W-1:0] res, core_a, core_b, core_r;
  logic [IW-1:0] res_id;
  logic err, busy, core_start, core_done;

  gcd_arbiter #(.W(W), .N(N), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .res(res), .res_id(res_id), .err(err), .busy(busy),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_r(core_r)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // behavioural core: loads while start is low, done in the 5th cycle with start high
  logic [W-1:0] la = '0;
  logic [W-1:0] lb = '0;
  int ccnt = 0;
  bit hang = 1'b0;
  always @(posedge clk) begin
    if (!core_start) begin
      la <= core_a;
      lb <= core_b;
      ccnt <= 0;
    end else ccnt <= ccnt + 1;
  end
  assign core_done = core_start && !hang && (ccnt == 4);
  assign core_r = gcd(la, lb);

  typedef struct {
    int id;
    logic [W-1:0] res;
    bit err;
    int runs;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int loads = 0;
  int runs = 0;
  int model_ptr = 0;
  int hold[N];

  function automatic void chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endfunction

  // monitor: pops one expectation per ack and checks the result plus the LOAD/RUN cycle counts
  always @(negedge clk) begin
    if (!rst) begin
      loads = 0;
      runs = 0;
    end else if (ack != 0) begin
      chk("ack_onehot", $countones(ack), 1);
      if (exp_q.size() == 0) chk("unexpected_ack", ack, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("ack_id", ack, 1 << mon_e.id);
        chk("res_id", res_id, mon_e.id);
        chk("res", res, mon_e.res);
        chk("err", err, mon_e.err);
        chk("load_cycles", loads, 1);
        chk("run_cycles", runs, mon_e.runs);
      end
      loads = 0;
      runs = 0;
    end else begin
      if (busy && !core_start) loads++;
      if (core_start) runs++;
    end
  end

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic push(input int id, input logic [W-1:0] r, input bit e, input int n);
    exp_t x;
    x.id = id;
    x.res = r;
    x.err = e;
    x.runs = n;
    exp_q.push_back(x);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (ack[i]) begin
          if (hold[i] > 0) hold[i]--;
          else req[i] = 1'b0;
        end
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // reference order: all requests pending together, served first-at-or-after pointer
  task automatic batch(input logic [N-1:0] mask, input bit to);
    logic [N-1:0] p = mask;
    while (p != 0) begin
      for (int k = 0; k < N; k++) begin
        int j = (model_ptr + k) % N;
        if (p[j]) begin
          push(j, to ? '0 : gcd(op_a[j*W +: W], op_b[j*W +: W]), to, to ? TMO : 5);
          p[j] = 1'b0;
          model_ptr = (j + 1) % N;
          break;
        end
      end
    end
    req = mask;
    drain();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_res"}, res, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_a"}, core_a, 0);
    chk({tag, "_core_b"}, core_b, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) hold[i] = 0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    #1;
    // single request
    set_ops(0, 48, 18);
    batch(4'b0001, 1'b0);
    // reset while RUN, in-flight result must vanish
    set_ops(1, 9, 6);
    req[1] = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("busy_before_rst", busy, 1);
    rst = 1'b0;
    req = '0;
    #1;
    chk_reset_vals("midrun");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    model_ptr = 0;
    repeat (12) @(negedge clk);
    #1;
    chk("idle_after_rst", busy, 0);
    // all four at pointer 0
    set_ops(0, 12, 8);
    set_ops(1, 9, 6);
    set_ops(2, 35, 14);
    set_ops(3, 17, 5);
    batch(4'b1111, 1'b0);
    // fairness: req0 held, req2 raised once during 0's run
    set_ops(0, 48, 18);
    push(0, 6, 1'b0, 5);
    push(2, 7, 1'b0, 5);
    push(0, 6, 1'b0, 5);
    hold[0] = 1;
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    req[2] = 1'b1;
    drain();
    model_ptr = 1;
    // operand change after grant, req dropped during RUN
    set_ops(0, 48, 18);
    push(0, 6, 1'b0, 5);
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    op_a[0 +: W] = 16'd100;
    repeat (2) @(negedge clk);
    #1;
    req[0] = 1'b0;
    drain();
    model_ptr = 1;
    // random batches, zero operands included
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++)
        set_ops(i, ($urandom_range(0, 7) == 0) ? 16'd0 : W'($urandom_range(0, 3000)),
                   ($urandom_range(0, 7) == 0) ? 16'd0 : W'($urandom_range(0, 3000)));
      batch(N'($urandom_range(1, 15)), 1'b0);
    end
`ifdef GCD_TIMEOUT_EN
    hang = 1'b1;
    set_ops(2, 30, 12);
    set_ops(3, 21, 14);
    batch(4'b1100, 1'b1);
    hang = 1'b0;
    set_ops(1, 30, 12);
    batch(4'b0010, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
